// File: rtl/alu_operand_stage_if.sv
// Signal bundle for alu_operand_stage: instruction handshake, writeback port and ALU-side outputs.
// The stage uses the slave modport; the producer/ALU side uses master.
interface alu_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  dest;
  logic        dest_wr;

  modport master (
    output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, operandA, operandB, opcode, funct, dest, dest_wr
  );

  modport slave (
    input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, operandA, operandB, opcode, funct, dest, dest_wr
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: decode, register file read, busy scoreboard, registered ALU operands.
// Optional feature macro: OPERAND_FORWARD_EN (writeback-to-source bypass in the issue cycle).
`ifndef RTYPE_OP
`define RTYPE_OP 6'b000000
`endif
`ifndef ADDI_OP
`define ADDI_OP 6'b001000
`endif
`ifndef XORI_OP
`define XORI_OP 6'b001110
`endif
`ifndef BEQ_OP
`define BEQ_OP 6'b000100
`endif
`ifndef BNE_OP
`define BNE_OP 6'b000101
`endif
`ifndef JR_FUNCT
`define JR_FUNCT 6'b001000
`endif

module alu_operand_stage (
  input  logic               clk,
  input  logic               reset,
  alu_operand_stage_if.slave bus
);
  logic [31:0] rf_reg [32];
  logic [31:0] busy_reg;
  logic [31:0] busy_next;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        use_rt;
  logic        wr_dec;
  logic [4:0]  dest_dec;
  logic [31:0] b_dec;
  logic        hazard;
  logic        accept;

  assign op     = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign fn     = bus.instr[5:0];
  assign imm_sx = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign imm_zx = {16'h0000, bus.instr[15:0]};

`ifdef OPERAND_FORWARD_EN
  assign fwd_a = bus.wb_en && (bus.wb_addr == rs) && (rs != 5'd0);
  assign fwd_b = bus.wb_en && (bus.wb_addr == rt) && (rt != 5'd0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign src_a = (rs == 5'd0) ? 32'h0 : (fwd_a ? bus.wb_data : rf_reg[rs]);
  assign src_b = (rt == 5'd0) ? 32'h0 : (fwd_b ? bus.wb_data : rf_reg[rt]);

  always_comb begin
    use_rt   = 1'b0;
    b_dec    = imm_sx;
    dest_dec = rt;
    wr_dec   = 1'b0;
    case (op)
      `RTYPE_OP: begin
        use_rt   = 1'b1;
        b_dec    = src_b;
        dest_dec = rd;
        wr_dec   = (fn != `JR_FUNCT);
      end
      `ADDI_OP: wr_dec = 1'b1;
      `XORI_OP: begin
        b_dec  = imm_zx;
        wr_dec = 1'b1;
      end
      `BEQ_OP, `BNE_OP: begin
        use_rt   = 1'b1;
        b_dec    = src_b;
        dest_dec = 5'd0;
      end
      default: ;
    endcase
    if (dest_dec == 5'd0)
      wr_dec = 1'b0;
  end

  // A source being written back this cycle is only cleared early when it is bypassed.
  assign hazard = (busy_reg[rs] && !fwd_a)
               || (use_rt && busy_reg[rt] && !fwd_b)
               || (wr_dec && busy_reg[dest_dec]);

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  // Per-register scoreboard update: a new claim beats a same-cycle writeback clear.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (accept && wr_dec && (dest_dec == 5'(gi))) ? 1'b1 :
                             (bus.wb_en && (bus.wb_addr == 5'(gi)))     ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        rf_reg[i] <= '0;
    end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
      rf_reg[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.operandA  <= '0;
      bus.operandB  <= '0;
      bus.opcode    <= '0;
      bus.funct     <= '0;
      bus.dest      <= '0;
      bus.dest_wr   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.operandA  <= src_a;
      bus.operandB  <= b_dec;
      bus.opcode    <= op;
      bus.funct     <= fn;
      bus.dest      <= dest_dec;
      bus.dest_wr   <= wr_dec;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized + directed bench for alu_operand_stage against a spec-level reference model.
`ifndef RTYPE_OP
`define RTYPE_OP 6'b000000
`endif
`ifndef ADDI_OP
`define ADDI_OP 6'b001000
`endif
`ifndef XORI_OP
`define XORI_OP 6'b001110
`endif
`ifndef BEQ_OP
`define BEQ_OP 6'b000100
`endif
`ifndef BNE_OP
`define BNE_OP 6'b000101
`endif
`ifndef JR_FUNCT
`define JR_FUNCT 6'b001000
`endif
`ifndef ADD_FUNCT
`define ADD_FUNCT 6'b100000
`endif

module tb_alu_operand_stage;
`ifdef OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [5:0] OP_R    = `RTYPE_OP;
  localparam logic [5:0] OP_ADDI = `ADDI_OP;
  localparam logic [5:0] OP_XORI = `XORI_OP;
  localparam logic [5:0] OP_BEQ  = `BEQ_OP;
  localparam logic [5:0] OP_BNE  = `BNE_OP;
  localparam logic [5:0] F_JR    = `JR_FUNCT;
  localparam logic [5:0] F_ADD   = `ADD_FUNCT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();
  alu_operand_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference model state
  logic [31:0] m_rf [32];
  bit   [31:0] m_busy;
  logic        m_ov;
  logic [31:0] m_a, m_b;
  logic [5:0]  m_op, m_fn;
  logic [4:0]  m_dest;
  logic        m_dw;
  logic        last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {OP_R, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (FWD && bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return m_rf[r];
  endfunction

  function automatic bit src_busy(input logic [4:0] r);
    return m_busy[r] && !(FWD && bus.wb_en && bus.wb_addr == r);
  endfunction

  // What the instruction word means, per the ISA rules, given current model state.
  function automatic void predict(input logic [31:0] ins, output logic [31:0] a,
                                  output logic [31:0] b, output logic [4:0] d,
                                  output logic dw, output logic haz);
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    bit          two_src;
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    imm = ins[15:0];
    a   = rd_reg(rs);
    b   = {{16{imm[15]}}, imm};
    d   = rt;
    dw  = 1'b0;
    two_src = 1'b0;
    if (op == OP_R) begin
      b = rd_reg(rt); d = ins[15:11]; dw = (ins[5:0] != F_JR); two_src = 1'b1;
    end else if (op == OP_ADDI) begin
      dw = 1'b1;
    end else if (op == OP_XORI) begin
      b = {16'h0, imm}; dw = 1'b1;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      b = rd_reg(rt); d = 5'd0; two_src = 1'b1;
    end
    if (d == 5'd0) dw = 1'b0;
    haz = src_busy(rs) || (two_src && src_busy(rt)) || (dw && m_busy[d]);
  endfunction

  function automatic logic exp_ready();
    logic [31:0] a, b;
    logic [4:0]  d;
    logic        dw, haz;
    predict(bus.instr, a, b, d, dw, haz);
    return (!m_ov || bus.out_ready) && !haz;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_busy = '0; m_ov = 1'b0; m_a = '0; m_b = '0;
    m_op = '0; m_fn = '0; m_dest = '0; m_dw = 1'b0; last_acc = 1'b0;
  endtask

  task automatic model_update();
    logic [31:0] a, b;
    logic [4:0]  d;
    logic        dw, haz, acc;
    predict(bus.instr, a, b, d, dw, haz);
    acc = bus.in_valid && (!m_ov || bus.out_ready) && !haz;
    if (acc) begin
      m_ov = 1'b1; m_a = a; m_b = b; m_op = bus.instr[31:26];
      m_fn = bus.instr[5:0]; m_dest = d; m_dw = dw;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    if (bus.wb_en) m_busy[bus.wb_addr] = 1'b0;
    if (acc && dw) m_busy[d] = 1'b1;
    m_busy[0] = 1'b0;
    if (bus.wb_en && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] = bus.wb_data;
    last_acc = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("in_ready", bus.in_ready, exp_ready());
      chk("out_valid", bus.out_valid, m_ov);
      if (m_ov) begin
        chk("operandA", bus.operandA, m_a);
        chk("operandB", bus.operandB, m_b);
        chk("opcode", bus.opcode, m_op);
        chk("funct", bus.funct, m_fn);
        chk("dest", bus.dest, m_dest);
        chk("dest_wr", bus.dest_wr, m_dw);
      end
    end
  end

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dest_wr", bus.dest_wr, 0);
    chk("rst_operandA", bus.operandA, 0);
    chk("rst_operandB", bus.operandB, 0);
    chk("rst_opcode", bus.opcode, 0);
    chk("rst_funct", bus.funct, 0);
    chk("rst_dest", bus.dest, 0);
    model_clear();
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_in_ready", bus.in_ready, 1);
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: begin
        case ($urandom_range(0, 2))
          0:       fn = F_ADD;
          1:       fn = F_JR;
          default: fn = 6'($urandom);
        endcase
        return {OP_R, rs, rt, rd, 5'($urandom), fn};
      end
      1: return mk_i(OP_ADDI, rs, rt, 16'($urandom));
      2: return mk_i(OP_XORI, rs, rt, 16'($urandom));
      3: return mk_i(OP_BEQ, rs, rt, 16'($urandom));
      4: return mk_i(OP_BNE, rs, rt, 16'($urandom));
      default: return mk_i(6'($urandom), rs, rt, 16'($urandom));
    endcase
  endfunction

  initial begin
    bit hold;
    bit did_rst;
    int nb;
    logic [4:0] busy_list [32];

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.instr = '0; bus.wb_en = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por_out_valid", bus.out_valid, 0);
    #2 reset = 1'b0;
    #1 chk("por_in_ready", bus.in_ready, 1);
    tick();
    chk_en = 1'b1;

    // ADDI sign extension, positive then negative immediate
    bus.in_valid = 1'b1; bus.instr = mk_i(OP_ADDI, 5'd0, 5'd1, 16'h1B58);
    tick();
    bus.instr = mk_i(OP_ADDI, 5'd0, 5'd5, 16'hC950);
    #1;
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_A", bus.operandA, 0);
    chk("addi_B", bus.operandB, 32'd7000);
    chk("addi_dest", bus.dest, 1);
    chk("addi_dw", bus.dest_wr, 1);
    tick();
    bus.instr = mk_i(OP_XORI, 5'd0, 5'd2, 16'h8001);
    #1 chk("addi_neg_B", bus.operandB, 32'hFFFFC950);
    tick();
    // RAW hazard on r1
    bus.instr = mk_r(5'd1, 5'd1, 5'd4, F_ADD);
    #1;
    chk("xori_B", bus.operandB, 32'h00008001);
    chk("xori_dest", bus.dest, 2);
    chk("raw_stall0", bus.in_ready, 0);
    tick();
    #1 chk("raw_stall1", bus.in_ready, 0);
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd21000;
    #1 chk("raw_wb_ready", bus.in_ready, FWD ? 32'd1 : 32'd0);
    tick();
    bus.wb_en = 1'b0;
    if (!FWD) begin
      #1 chk("raw_retry_ready", bus.in_ready, 1);
      tick();
    end
    // Backpressure with a waiting instruction
    bus.out_ready = 1'b0;
    bus.instr = mk_i(OP_XORI, 5'd0, 5'd6, 16'h0003);
    #1;
    chk("raw_A", bus.operandA, 32'd21000);
    chk("raw_B", bus.operandB, 32'd21000);
    chk("raw_dest", bus.dest, 4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_hold_A", bus.operandA, 32'd21000);
      tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", bus.in_ready, 1);
    tick();
    bus.instr = mk_r(5'd0, 5'd0, 5'd0, F_ADD);
    #1;
    chk("bp_B", bus.operandB, 3);
    chk("bp_opcode", bus.opcode, 32'(OP_XORI));
    // Register 0 as destination, then an r0 reader
    tick();
    bus.instr = mk_i(OP_ADDI, 5'd0, 5'd7, 16'h0001);
    #1;
    chk("r0_dw", bus.dest_wr, 0);
    chk("r0_reader_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd637483644;
    tick();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b1; bus.instr = mk_i(OP_BEQ, 5'd3, 5'd3, 16'h0010);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("beq_A", bus.operandA, 32'd637483644);
    chk("beq_B", bus.operandB, 32'd637483644);
    chk("beq_dw", bus.dest_wr, 0);
    mid_reset();

    // Randomized phase
    hold = 1'b0;
    did_rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 1500 && !did_rst && hold) begin
        mid_reset();
        did_rst = 1'b1;
        hold = 1'b0;
        continue;
      end
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.instr    = rand_instr();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.wb_en     = $urandom_range(0, 1) == 1;
      bus.wb_data   = $urandom;
      nb = 0;
      for (int r = 1; r < 32; r++)
        if (m_busy[r]) begin busy_list[nb] = 5'(r); nb++; end
      if (nb > 0 && $urandom_range(0, 4) != 0)
        bus.wb_addr = busy_list[$urandom_range(0, nb - 1)];
      else
        bus.wb_addr = 5'($urandom_range(0, 7));
      tick();
      hold = bus.in_valid && !last_acc;
    end
    bus.in_valid = 1'b0;
    bus.wb_en = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
